// File: rtl/nes_pad_pkg.sv
// Shared constants for the NES joypad responder: button bit positions,
// pad width and the idle/reset line levels of the console-side wires.
package nes_pad_pkg;

  localparam int PAD_BITS  = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic PAD_DATA_RST   = 1'b1;
  localparam logic PAD_CLK_IDLE   = 1'b1;
  localparam logic PAD_LATCH_IDLE = 1'b0;

  localparam logic [3:0] BIT_COUNT_MAX  = 4'(PAD_BITS);
  localparam logic [3:0] BIT_COUNT_LAST = 4'(PAD_BITS - 1);

  typedef logic [PAD_BITS-1:0] pad_bits_t;

endpackage

// File: rtl/pad_input_sync.sv
// Synchronizer plus deglitch filter for one asynchronous console wire.
// Emits the accepted level and one-cycle pulses marking each accepted edge.
module pad_input_sync #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // The counter tracks consecutive samples disagreeing with the accepted level;
  // any agreeing sample restarts it, so short pulses never reach the level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= {SYNC_STAGES{RESET_VAL}};
      r_cnt   <= '0;
      r_level <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= w_sync;
        r_cnt   <= '0;
        r_rise  <= w_sync;
        r_fall  <= ~w_sync;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/joypad_responder.sv
// Device-side NES joypad: CD4021-style parallel-load / serial-out register
// answering the console latch/clock polling protocol, A bit first, active-low.
module joypad_responder
  import nes_pad_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] buttons,
  input  logic       pad_latch,
  input  logic       pad_clk,
  output logic       pad_data,
  output logic [7:0] snapshot,
  output logic [3:0] bit_count,
  output logic       poll_done
);

  logic      w_latch_f;
  logic      w_latch_rise;
  logic      w_latch_fall;
  logic      w_clk_f;
  logic      w_clk_rise;
  logic      w_clk_fall;
  logic      w_unused_edges;

  pad_bits_t r_shreg;
  pad_bits_t r_snapshot;
  logic [3:0] r_bit_count;
  logic       r_poll_done;

  pad_input_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES),
    .RESET_VAL    (PAD_LATCH_IDLE)
  ) u_latch_sync (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_async(pad_latch),
    .o_level(w_latch_f),
    .o_rise (w_latch_rise),
    .o_fall (w_latch_fall)
  );

  pad_input_sync #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES),
    .RESET_VAL    (PAD_CLK_IDLE)
  ) u_clk_sync (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_async(pad_clk),
    .o_level(w_clk_f),
    .o_rise (w_clk_rise),
    .o_fall (w_clk_fall)
  );

  assign w_unused_edges = w_latch_rise | w_clk_fall | w_clk_f;

  // Latch high is a continuous load and overrides any clock edge; shifting in
  // a zero makes reads past the eighth bit return "1" at the host.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg     <= {PAD_BITS{PAD_DATA_RST}};
      r_snapshot  <= '0;
      r_bit_count <= '0;
      r_poll_done <= 1'b0;
    end else begin
      r_poll_done <= 1'b0;
      if (w_latch_f) begin
        r_shreg     <= ~buttons;
        r_bit_count <= '0;
      end else begin
        if (w_latch_fall) begin
          r_snapshot <= buttons;
        end
        if (w_clk_rise) begin
          r_shreg <= {1'b0, r_shreg[PAD_BITS-1:1]};
          if (r_bit_count < BIT_COUNT_MAX) begin
            r_bit_count <= r_bit_count + 4'd1;
          end
          if (r_bit_count == BIT_COUNT_LAST) begin
            r_poll_done <= 1'b1;
          end
        end
      end
    end
  end

  assign pad_data  = r_shreg[0];
  assign snapshot  = r_snapshot;
  assign bit_count = r_bit_count;
  assign poll_done = r_poll_done;

endmodule

// File: tb/tb_joypad_responder.sv
// Directed bench for joypad_responder with default parameters.
module tb_joypad_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] buttons = 8'h00;
  logic       pad_latch = 1'b0;
  logic       pad_clk = 1'b1;
  logic       pad_data;
  logic [7:0] snapshot;
  logic [3:0] bit_count;
  logic       poll_done;

  int checks = 0;
  int failures = 0;
  int pd_cnt = 0;

  joypad_responder dut (
    .clk      (clk),
    .rst      (rst),
    .buttons  (buttons),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .pad_data (pad_data),
    .snapshot (snapshot),
    .bit_count(bit_count),
    .poll_done(poll_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (poll_done === 1'b1) pd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic latch_pulse(input int hi_cycles);
    pad_latch = 1'b1;
    repeat (hi_cycles) @(negedge clk);
    pad_latch = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic read_one(output logic d);
    pad_clk = 1'b0;
    repeat (20) @(negedge clk);
    d = pad_data;
    pad_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic read_byte(output logic [7:0] bits);
    logic d;
    for (int i = 0; i < 8; i++) begin
      read_one(d);
      bits[i] = d;
    end
  endtask

  initial begin
    logic [7:0] bits;
    logic       d;

    // reset
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pad_data", 32'(pad_data), 32'h1);
    check("rst_bit_count", 32'(bit_count), 32'h0);
    check("rst_snapshot", 32'(snapshot), 32'h00);
    check("rst_poll_done", 32'(poll_done), 32'h0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_poll", 32'(pd_cnt), 32'd0);
    check("post_rst_pad_data", 32'(pad_data), 32'h1);

    // A+Start poll
    buttons = 8'h09;
    latch_pulse(12);
    check("t2_snapshot", 32'(snapshot), 32'h09);
    check("t2_count_after_load", 32'(bit_count), 32'd0);
    read_byte(bits);
    check("t2_serial_bits", 32'(bits), 32'hF6);
    check("t2_bit_count", 32'(bit_count), 32'd8);
    check("t2_poll_once", 32'(pd_cnt), 32'd1);

    // reads past the eighth bit
    for (int i = 0; i < 4; i++) begin
      read_one(d);
      check("t3_extra_read", 32'(d), 32'h0);
    end
    check("t3_bit_count_sat", 32'(bit_count), 32'd8);
    check("t3_no_repoll", 32'(pd_cnt), 32'd1);

    // buttons changed after latch fall are ignored until next load
    buttons = 8'h01;
    latch_pulse(12);
    buttons = 8'h80;
    read_byte(bits);
    check("t4_old_bits", 32'(bits), 32'hFE);
    check("t4_old_snapshot", 32'(snapshot), 32'h01);
    latch_pulse(12);
    read_byte(bits);
    check("t4_new_bits", 32'(bits), 32'h7F);
    check("t4_new_snapshot", 32'(snapshot), 32'h80);
    check("t4_poll_count", 32'(pd_cnt), 32'd3);

    // short glitches are discarded
    buttons = 8'h00;
    latch_pulse(12);
    for (int i = 0; i < 3; i++) read_one(d);
    check("t5_count_before", 32'(bit_count), 32'd3);
    pad_clk = 1'b0;
    repeat (2) @(negedge clk);
    pad_clk = 1'b1;
    repeat (15) @(negedge clk);
    check("t5_clk_glitch_count", 32'(bit_count), 32'd3);
    check("t5_clk_glitch_data", 32'(pad_data), 32'h1);
    buttons = 8'hFF;
    pad_latch = 1'b1;
    repeat (2) @(negedge clk);
    pad_latch = 1'b0;
    repeat (15) @(negedge clk);
    check("t5_latch_glitch_count", 32'(bit_count), 32'd3);
    check("t5_latch_glitch_data", 32'(pad_data), 32'h1);

    // latch mid-sequence aborts and reloads after seven cycles
    pad_latch = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("t6_data_before_latency", 32'(pad_data), 32'h1);
    @(posedge clk);
    #1 check("t6_data_reloaded", 32'(pad_data), 32'h0);
    check("t6_count_cleared", 32'(bit_count), 32'd0);
    @(negedge clk);
    pad_latch = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_no_poll", 32'(pd_cnt), 32'd3);
    check("t6_snapshot", 32'(snapshot), 32'hFF);

    // asynchronous reset mid-sequence
    read_one(d);
    read_one(d);
    check("t7_count_before_rst", 32'(bit_count), 32'd2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t7_rst_pad_data", 32'(pad_data), 32'h1);
    check("t7_rst_bit_count", 32'(bit_count), 32'h0);
    check("t7_rst_snapshot", 32'(snapshot), 32'h00);
    check("t7_rst_poll_done", 32'(poll_done), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
